// File: rtl/req_ack_arbiter.sv
// req_ack_arbiter: round-robin arbiter that shares one upstream req/ack token
// channel among num_req downstream consumers. Every upstream token is
// delivered to exactly one winner. The handshake is a level req with a
// one-cycle ack.
//
// Optional feature: define REQ_ACK_ARBITER_STATS_EN to add the grant_count
// (32 bits per requester) and wait_cycles delivery/stall counters.
module req_ack_arbiter #(
  parameter int num_req    = 2,
  parameter int data_width = 32,
  parameter int sel_width  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [num_req-1:0]    req_dn,
  output logic [num_req-1:0]    ack_dn,
  output logic [data_width-1:0] dout,
  output logic                  req_up,
  input  logic                  ack_up,
  input  logic [data_width-1:0] din_up,
  output logic [sel_width-1:0]  grant_id,
  output logic                  busy,
  output logic                  err
`ifdef REQ_ACK_ARBITER_STATS_EN
  ,
  output logic [32*num_req-1:0] grant_count,
  output logic [31:0]           wait_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q;
  logic [sel_width-1:0]  ptr_q;
  logic [sel_width-1:0]  ptr_d;
  logic [sel_width-1:0]  grant_q;
  logic [num_req-1:0]    ack_dn_q;
  logic [data_width-1:0] dout_q;
  logic                  req_up_q;
  logic                  busy_q;
  logic                  err_q;

  logic                  win_valid;
  logic [sel_width-1:0]  win_idx;
  logic                  hi_valid;
  logic [sel_width-1:0]  hi_idx;
  logic [sel_width-1:0]  lo_idx;
  logic [num_req-1:0]    grant_onehot;

  // Round-robin pick: lowest requester at or above ptr, else lowest overall (wrap).
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    hi_valid  = 1'b0;
    hi_idx    = '0;
    win_valid = 1'b0;
    lo_idx    = '0;
    for (int i = 0; i < num_req; i++) begin
      if (req_dn[i] && !hi_valid && (i >= int'(ptr_q))) begin
        hi_valid = 1'b1;
        hi_idx   = sel_width'(i);
      end
      if (req_dn[i] && !win_valid) begin
        win_valid = 1'b1;
        lo_idx    = sel_width'(i);
      end
    end
    win_idx = hi_valid ? hi_idx : lo_idx;
  end

  // Decode the registered winner to the one-hot delivery strobe and the next pointer.
  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < num_req; i++) begin
      grant_onehot[i] = (int'(grant_q) == i);
    end
    ptr_d = (int'(grant_q) == num_req - 1) ? '0 : grant_q + sel_width'(1);
  end

  // Arbitration FSM with registered handshake outputs; ack_up outside WAIT is flagged sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      ack_dn_q <= '0;
      dout_q   <= '0;
      req_up_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      ack_dn_q <= '0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (ack_up) begin
            err_q <= 1'b1;
          end
          if (win_valid) begin
            grant_q  <= win_idx;
            req_up_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_WAIT;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // The winner is committed: a dropped req_dn still receives the token.
          if (ack_up) begin
            dout_q   <= din_up;
            ack_dn_q <= grant_onehot;
            req_up_q <= 1'b0;
            busy_q   <= 1'b0;
            ptr_q    <= ptr_d;
            state_q  <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_dn   = ack_dn_q;
  assign dout     = dout_q;
  assign req_up   = req_up_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign err      = err_q;

`ifdef REQ_ACK_ARBITER_STATS_EN
  logic [32*num_req-1:0] grant_count_q;
  logic [31:0]           wait_cycles_q;

  // Per-requester delivery counters and WAIT-cycle counter, all free-running with wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_count_q <= '0;
      wait_cycles_q <= '0;
    end else begin
      for (int i = 0; i < num_req; i++) begin
        if (ack_dn_q[i]) begin
          grant_count_q[i*32 +: 32] <= grant_count_q[i*32 +: 32] + 32'd1;
        end
      end
      if (state_q == ST_WAIT) begin
        wait_cycles_q <= wait_cycles_q + 32'd1;
      end
    end
  end

  assign grant_count = grant_count_q;
  assign wait_cycles = wait_cycles_q;
`endif

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Self-checking bench for req_ack_arbiter (num_req=3). A producer model answers
// req_up one cycle late with incrementing tokens. Each test pushes the
// expected (winner, token) pairs into a scoreboard, and a monitor pops one
// entry on every ack_dn pulse.
module tb_req_ack_arbiter;
  localparam int NR = 3;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_dn;
  logic [NR-1:0] ack_dn;
  logic [DW-1:0] dout;
  logic          req_up;
  logic          ack_up;
  logic [DW-1:0] din_up;
  logic [SW-1:0] grant_id;
  logic          busy;
  logic          err;
`ifdef REQ_ACK_ARBITER_STATS_EN
  logic [32*NR-1:0] grant_count;
  logic [31:0]      wait_cycles;
`endif

  req_ack_arbiter #(.num_req(NR), .data_width(DW), .sel_width(SW)) dut (
    .clk(clk), .rst(rst), .req_dn(req_dn), .ack_dn(ack_dn), .dout(dout),
    .req_up(req_up), .ack_up(ack_up), .din_up(din_up), .grant_id(grant_id),
    .busy(busy), .err(err)
`ifdef REQ_ACK_ARBITER_STATS_EN
    , .grant_count(grant_count), .wait_cycles(wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            first_ack_cyc = -1;
  int            last_ack_cyc = -1;
  int            last_gap = 0;
  logic [DW-1:0] tok_val = '0;
  logic          force_ack = 1'b0;
  logic          req_seen = 1'b0;

  always @(posedge clk) cyc++;

  // Upstream producer: acks once req_up has been visible for a full cycle.
  initial begin
    ack_up = 1'b0;
    din_up = '0;
    forever begin
      @(negedge clk);
      if (force_ack) begin
        ack_up = 1'b1;
        din_up = 32'hDEAD_BEEF;
      end else if (req_up && req_seen && !ack_up) begin
        ack_up  = 1'b1;
        din_up  = tok_val;
        tok_val = tok_val + 1;
      end else begin
        ack_up = 1'b0;
      end
      req_seen = req_up;
    end
  end

  // Monitor: every ack_dn pulse must match the next scoreboard entry.
  initial begin
    exp_t          e;
    logic [NR-1:0] exp_ack;
    forever begin
      @(negedge clk);
      if (rst && ack_dn !== '0) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack ack_dn=%b dout=%0h required=no delivery", ack_dn, dout);
        end else begin
          e = sb_q.pop_front();
          exp_ack = '0;
          exp_ack[e.id] = 1'b1;
          checks++;
          if (ack_dn !== exp_ack) begin
            failures++;
            $display("FAIL ack_dn got=%b required=%b", ack_dn, exp_ack);
          end
          checks++;
          if (dout !== e.data) begin
            failures++;
            $display("FAIL dout got=%0h required=%0h", dout, e.data);
          end
          checks++;
          if (grant_id !== SW'(e.id)) begin
            failures++;
            $display("FAIL grant_id got=%0d required=%0d", grant_id, e.id);
          end
        end
        if (first_ack_cyc < 0) first_ack_cyc = cyc;
        if (last_ack_cyc >= 0) last_gap = cyc - last_ack_cyc;
        last_ack_cyc = cyc;
      end
    end
  end

  task automatic do_reset();
    req_dn = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    tok_val = '0;
    first_ack_cyc = -1;
    last_ack_cyc = -1;
    last_gap = 0;
  endtask

  task automatic push_exp(input int id, input logic [DW-1:0] data);
    exp_t e;
    e.id = id;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d required=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    req_dn = '0;
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({ack_dn, req_up, busy, err} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b required=0", {ack_dn, req_up, busy, err});
    end
    checks++;
    if (dout !== '0 || grant_id !== '0) begin
      failures++;
      $display("FAIL reset_data dout=%0h grant_id=%0d required=0/0", dout, grant_id);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_up !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req req_up=%b busy=%b required=0/0", req_up, busy);
    end
  endtask

  task automatic test_single();
    int start;
    do_reset();
    for (int k = 0; k < 4; k++) push_exp(0, DW'(k));
    req_dn = 3'b001;
    start = cyc;
    wait_drain("single");
    req_dn = '0;
    checks++;
    if (first_ack_cyc - start !== 3) begin
      failures++;
      $display("FAIL first_latency got=%0d required=3", first_ack_cyc - start);
    end
    checks++;
    if (last_gap !== 3) begin
      failures++;
      $display("FAIL token_period got=%0d required=3", last_gap);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (dout !== 32'd3 || busy !== 1'b0 || req_up !== 1'b0) begin
      failures++;
      $display("FAIL single_hold dout=%0h busy=%b req_up=%b required=3/0/0", dout, busy, req_up);
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int k = 0; k < 9; k++) push_exp(k % 3, DW'(k));
    req_dn = 3'b111;
    wait_drain("contention");
    req_dn = '0;
`ifdef REQ_ACK_ARBITER_STATS_EN
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (grant_count[i*32 +: 32] !== 32'd3) begin
        failures++;
        $display("FAIL grant_count[%0d] got=%0d required=3", i, grant_count[i*32 +: 32]);
      end
    end
    checks++;
    if (wait_cycles !== 32'd18) begin
      failures++;
      $display("FAIL wait_cycles got=%0d required=18", wait_cycles);
    end
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic test_skip();
    do_reset();
    push_exp(0, 32'd0);
    push_exp(2, 32'd1);
    push_exp(0, 32'd2);
    push_exp(2, 32'd3);
    req_dn = 3'b101;
    wait_drain("skip");
    req_dn = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_withdraw();
    int n = 0;
    do_reset();
    tok_val = 32'h55;
    push_exp(1, 32'h55);
    req_dn = 3'b010;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL withdraw_busy got=%b required=1", busy);
    end
    @(negedge clk);
    req_dn = '0;
    wait_drain("withdraw");
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_state err=%b busy=%b required=0/0", err, busy);
    end
  endtask

  task automatic test_spurious();
    logic [DW-1:0] saved;
    req_dn = '0;
    saved = dout;
    @(posedge clk);
    #1 force_ack = 1'b1;
    @(posedge clk);
    #1 force_ack = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL spurious_err got=%b required=1", err);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (dout !== saved || err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL spurious_hold dout=%0h err=%b busy=%b required=%0h/1/0", dout, err, busy, saved);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got=%b required=0", err);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    do_reset();
    push_exp(1, 32'd0);
    req_dn = 3'b110;
    wait_drain("pre_reset");
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b1 || grant_id !== SW'(2)) begin
      failures++;
      $display("FAIL rearb_wait busy=%b grant_id=%0d required=1/2", busy, grant_id);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ack_dn, req_up, busy, err} !== '0 || dout !== '0 || grant_id !== '0) begin
      failures++;
      $display("FAIL async_reset ctrl=%b dout=%0h grant_id=%0d required=0", {ack_dn, req_up, busy, err}, dout, grant_id);
    end
    @(negedge clk);
    rst = 1'b1;
    push_exp(0, 32'd1);
    req_dn = 3'b111;
    wait_drain("post_reset");
    req_dn = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    req_dn = '0;
    test_reset();
    test_single();
    test_contention();
    test_skip();
    test_withdraw();
    test_spurious();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_ack_arbiter.md
# req_ack_arbiter

Round-robin arbiter that shares one upstream req/ack data channel (a producer or an `out`/operator output port) among `num_req` downstream consumers. It sits between a single source of the asynchronous-operator network and several sinks that each need their own tokens, rather than a broadcast. Each upstream token is delivered to exactly one winning requester. It uses the same level-req / one-cycle-ack handshake as the rest of the dataflow fabric.

## Interface
Parameters:
- `num_req`, default 2: number of downstream requesters; legal range 1..16.
- `data_width`, default 32: token width.
- `sel_width`, default 4: width of `grant_id`; must satisfy 2^sel_width ≥ num_req.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_dn`  in  num_req  per-requester level request; bit i belongs to requester i.
- `ack_dn`  out  num_req  one-cycle, one-hot delivery strobe; `dout` is valid while it is high.
- `dout`  out  data_width  registered token for the requester whose `ack_dn` bit is high.
- `req_up`  out  1  request to the upstream producer.
- `ack_up`  in  1  upstream one-cycle ack; `din_up` is valid while it is high.
- `din_up`  in  data_width  upstream token.
- `grant_id`  out  sel_width  index of the current or most recent winner.
- `busy`  out  1  high in WAIT.
- `err`  out  1  sticky flag: `ack_up` arrived while not in WAIT.

## Operation
- Reset (`rst`=0, asynchronous) forces these values:
  - `ack_dn`=0, `dout`=0, `req_up`=0, `grant_id`=0, `busy`=0, `err`=0;
  - state=IDLE, priority pointer `ptr`=0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if any `req_dn` bit is high, choose the winner w. The winner is the first set bit scanning from `ptr` upward, wrapping modulo num_req. Register w into `grant_id`, set `req_up`=1 and `busy`=1, and go to WAIT. With no requests, stay in IDLE.
  - WAIT: hold `req_up`=1 until `ack_up`=1. On the ack edge:
    - `dout`←`din_up`, `ack_dn[w]`←1, `req_up`←0, `busy`←0;
    - `ptr`←(w+1) mod num_req;
    - go to DONE.
  - DONE: `ack_dn`←0. Re-arbitrate with the same rule as IDLE using the updated `ptr`. With a request pending, go to WAIT with `req_up`=1; otherwise go to IDLE.
- Requester i dropping `req_dn[i]` while it owns WAIT does not cancel the transaction, because upstream is already committed. The token is still delivered with `ack_dn[i]`.
- Requesters that are not the winner see `ack_dn`=0 and must keep `req_dn` asserted to remain eligible.
- `ack_up` in IDLE or DONE is ignored: no data capture and no `ack_dn`. It sets `err`, which clears only on reset.
- num_req=1 degenerates to a registered pass-through with a 3-cycle period.
- `dout` holds its last value between deliveries.

## Timing
- Reference edges: E0 = arbiter samples `req_dn` in IDLE; upstream producer acks one edge after it sees `req_up`.
  - After E0: `req_up`=1.
  - After E1: `ack_up`=1.
  - After E2: `ack_dn[w]`=1 and `dout` is valid. First-token latency is 3 edges.
- Sustained throughput is one token per 3 cycles.
  - `req_up` is low for exactly one cycle between back-to-back grants.
  - This guarantees upstream never sees req and ack high together at a re-issue.
- Fairness: with all requesters continuously active, grants cycle 0,1,…,num_req-1,0,…
  - No requester waits more than num_req grants.
- Reset mid-WAIT: the pending upstream ack is lost and no `ack_dn` is issued. The arbiter restarts in IDLE with `ptr`=0.

## Configuration
- `REQ_ACK_ARBITER_STATS_EN` defined:
  - Adds output `grant_count` of width 32*num_req. Slice i is a 32-bit counter of deliveries to requester i; it increments on each `ack_dn[i]` pulse and wraps at 2^32.
  - Adds output `wait_cycles` (32 bits), which counts cycles spent in WAIT and wraps.
  - Both reset to 0.
- Macro undefined: these ports and counters do not exist. Functional behaviour is otherwise identical.

## Test plan
- Single requester: num_req=2, `req_dn`=2'b01, producer starting at value 0 with no stalls → `ack_dn`=01 with `dout` 0,1,2,… one token per 3 cycles. The first `ack_dn` is high 3 edges after the first sample.
- Full contention: num_req=3, `req_dn`=3'b111, 9 tokens valued 0..8 → grant order 0,1,2,0,1,2,0,1,2. Requester 1 receives 1,4,7. With STATS_EN, each `grant_count` slice equals 3.
- Pointer wrap/skip: `req_dn`=3'b101 after a grant to requester 0 → next winner is 2, then 0. Requester 1 is never acked.
- Withdrawn request: requester 1 drops `req_dn[1]` one cycle into WAIT → `ack_dn[1]` still pulses with the upstream token, and `err` stays 0.
- Spurious ack: `ack_up` pulsed while `req_dn`=0 → no `ack_dn`, `dout` unchanged, and `err`=1 until reset.
- Reset mid-WAIT: assert `rst`=0 for 1 cycle while `busy`=1 → all outputs 0 immediately (asynchronous). The next grant goes to requester 0 first.
